mac32_rr_sched: RTL and testbench

- Round-robin scheduler that shares one FP32 MAC datapath (Result = A + B*C) between NUM_REQ requesters.
- Accepts operand triples per requester over a valid/ready handshake and issues at most one triple per cycle to the MAC.
- Tracks in-flight operations through the fixed MAC latency and returns each result tagged with its requester ID.
- Provides a flush/drain sequence used by the test harness before ending simulation.

---
 rtl/mac32_rr_sched.sv | 182 ++++++++++++++++++
 tb/tb_mac32_rr_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac32_rr_sched.sv
// mac32_rr_sched: round-robin share of one FP32 MAC (A + B*C) between NUM_REQ requesters; MAC32_SCHED_STATS_EN adds counters.
// Latency: accept -> mac_valid_o 1 cycle, accept -> res_valid_o MAC_LAT+2 cycles; one issue per cycle sustained.
// Backpressure: none from MAC or result side; grants are withheld only while draining (DRAIN/DONE).
module mac32_rr_sched #(
  parameter int PARM_XLEN = 32,
  parameter int NUM_REQ   = 2,
  parameter int MAC_LAT   = 3,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef MAC32_SCHED_STATS_EN
  output logic [NUM_REQ*16-1:0]        grant_cnt_o,
  output logic [15:0]                  stall_cnt_o,
`endif
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*PARM_XLEN-1:0] req_a_i,
  input  logic [NUM_REQ*PARM_XLEN-1:0] req_b_i,
  input  logic [NUM_REQ*PARM_XLEN-1:0] req_c_i,
  output logic                         mac_valid_o,
  output logic [PARM_XLEN-1:0]         mac_a_o,
  output logic [PARM_XLEN-1:0]         mac_b_o,
  output logic [PARM_XLEN-1:0]         mac_c_o,
  input  logic [PARM_XLEN-1:0]         mac_result_i,
  output logic                         res_valid_o,
  output logic [ID_W-1:0]              res_id_o,
  output logic [PARM_XLEN-1:0]         res_data_o,
  input  logic                         flush_i,
  output logic                         flush_done_o,
  output logic                         busy_o
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } stage_t;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic                 mac_valid_q, mac_valid_d;
  logic [ID_W-1:0]      mac_id_q, mac_id_d;
  logic [PARM_XLEN-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d, mac_c_q, mac_c_d;
  stage_t               stage_q [MAC_LAT];
  stage_t               stage_d [MAC_LAT];
  logic                 res_valid_q, res_valid_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;
  logic [PARM_XLEN-1:0] res_data_q, res_data_d;
  logic                 grant_vld;
  logic [ID_W-1:0]      grant_id;
  logic                 stage_any;

  // Search upward from the rr pointer; rst_n gates ready so every output is low while reset is held.
  always_comb begin
    int idx;
    idx         = 0;
    grant_vld   = 1'b0;
    grant_id    = '0;
    req_ready_o = '0;
    if (state_q == ST_RUN && rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = (int'(ptr_q) + i) % NUM_REQ;
        if (!grant_vld && req_valid_i[idx]) begin
          grant_vld = 1'b1;
          grant_id  = ID_W'(idx);
        end
      end
    end
    if (grant_vld) req_ready_o[grant_id] = 1'b1;
  end

  always_comb begin
    mac_valid_d = grant_vld;
    mac_id_d    = mac_id_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    mac_c_d     = mac_c_q;
    ptr_d       = ptr_q;
    if (grant_vld) begin
      mac_id_d = grant_id;
      mac_a_d  = req_a_i[int'(grant_id)*PARM_XLEN +: PARM_XLEN];
      mac_b_d  = req_b_i[int'(grant_id)*PARM_XLEN +: PARM_XLEN];
      mac_c_d  = req_c_i[int'(grant_id)*PARM_XLEN +: PARM_XLEN];
      ptr_d    = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end

    // Tag pipe mirrors the MAC latency so the last stage lines up with mac_result_i.
    stage_d[0] = {mac_valid_q, mac_id_q};
    for (int i = 1; i < MAC_LAT; i++) stage_d[i] = stage_q[i-1];
    stage_any = 1'b0;
    for (int i = 0; i < MAC_LAT; i++) stage_any = stage_any | stage_q[i].vld;

    res_valid_d = stage_q[MAC_LAT-1].vld;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    if (stage_q[MAC_LAT-1].vld) begin
      res_id_d   = stage_q[MAC_LAT-1].id;
      res_data_d = mac_result_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (flush_i) state_d = ST_DRAIN;
      ST_DRAIN: if (!stage_any && !mac_valid_q) state_d = ST_DONE;
      ST_DONE:  if (!flush_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ptr_q       <= '0;
      mac_valid_q <= 1'b0;
      mac_id_q    <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_c_q     <= '0;
      for (int i = 0; i < MAC_LAT; i++) stage_q[i] <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mac_valid_q <= mac_valid_d;
      mac_id_q    <= mac_id_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_c_q     <= mac_c_d;
      for (int i = 0; i < MAC_LAT; i++) stage_q[i] <= stage_d[i];
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
    end
  end

  assign mac_valid_o  = mac_valid_q;
  assign mac_a_o      = mac_a_q;
  assign mac_b_o      = mac_b_q;
  assign mac_c_o      = mac_c_q;
  assign res_valid_o  = res_valid_q;
  assign res_id_o     = res_id_q;
  assign res_data_o   = res_data_q;
  assign flush_done_o = (state_q == ST_DONE);
  assign busy_o       = stage_any | mac_valid_q | res_valid_q;

`ifdef MAC32_SCHED_STATS_EN
  logic [15:0] gcnt_q [NUM_REQ];
  logic [15:0] gcnt_d [NUM_REQ];
  logic [15:0] stall_q, stall_d;

  // A stall is a cycle with demand but no grant, which only happens in DRAIN/DONE.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) gcnt_d[k] = gcnt_q[k];
    stall_d = stall_q;
    if (grant_vld && gcnt_q[grant_id] != 16'hFFFF) gcnt_d[grant_id] = gcnt_q[grant_id] + 16'd1;
    if (|req_valid_i && !grant_vld && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) gcnt_q[k] <= '0;
      stall_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) gcnt_q[k] <= gcnt_d[k];
      stall_q <= stall_d;
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_gcnt
    assign grant_cnt_o[k*16 +: 16] = gcnt_q[k];
  end
  assign stall_cnt_o = stall_q;
`else
  // Default build carries no statistics state.
`endif

endmodule

// File: tb/tb_mac32_rr_sched.sv
// Bench for mac32_rr_sched: behavioural FP32 MAC with fixed latency, rr grant model and result scoreboard.
module tb_mac32_rr_sched;
  localparam int XLEN = 32;
  localparam int NREQ = 2;
  localparam int LAT  = 3;
  localparam int IDW  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [NREQ-1:0]        req_valid_i, req_ready_o;
  logic [NREQ*XLEN-1:0]   req_a_i, req_b_i, req_c_i;
  logic                   mac_valid_o;
  logic [XLEN-1:0]        mac_a_o, mac_b_o, mac_c_o, mac_result_i;
  logic                   res_valid_o;
  logic [IDW-1:0]         res_id_o;
  logic [XLEN-1:0]        res_data_o;
  logic                   flush_i, flush_done_o, busy_o;
`ifdef MAC32_SCHED_STATS_EN
  logic [NREQ*16-1:0]     grant_cnt_o;
  logic [15:0]            stall_cnt_o;
`endif

  mac32_rr_sched #(.PARM_XLEN(XLEN), .NUM_REQ(NREQ), .MAC_LAT(LAT), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MAC32_SCHED_STATS_EN
    .grant_cnt_o(grant_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i),
    .mac_valid_o(mac_valid_o), .mac_a_o(mac_a_o), .mac_b_o(mac_b_o), .mac_c_o(mac_c_o),
    .mac_result_i(mac_result_i),
    .res_valid_o(res_valid_o), .res_id_o(res_id_o), .res_data_o(res_data_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o), .busy_o(busy_o)
  );

  function automatic real fp2r(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_mac(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return r2fp(fp2r(a) + fp2r(b) * fp2r(c));
  endfunction

  function automatic logic [31:0] mkf(input int n);
    return r2fp(real'(n));
  endfunction

  // External MAC: fixed LAT-cycle pipe from the issue strobe.
  logic [31:0] mac_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) mac_pipe[i] <= mac_pipe[i-1];
    mac_pipe[0] <= mac_valid_o ? fp_mac(mac_a_o, mac_b_o, mac_c_o) : 32'h0;
  end
  assign mac_result_i = mac_pipe[LAT-1];

  typedef struct {
    int          id;
    logic [31:0] data;
    int          c;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];
  int  gnt_q[$];
  int  acc_cyc_q[$];
  int  mv_cyc_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  smp_cyc = 0;
  int  ptr_m   = 0;
  bit  model_run = 1'b1;
  logic [NREQ-1:0] last_rdy;
  logic last_fd, last_busy;

  task automatic clear_q();
    exp_q.delete(); got_q.delete(); gnt_q.delete(); acc_cyc_q.delete(); mv_cyc_q.delete();
  endtask

  task automatic drive(input logic [NREQ-1:0] v);
    req_valid_i = v;
    for (int k = 0; k < NREQ; k++) begin
      req_a_i[k*XLEN +: XLEN] = mkf((cyc % 7) + 1);
      req_b_i[k*XLEN +: XLEN] = mkf(k + 2);
      req_c_i[k*XLEN +: XLEN] = mkf((cyc % 5) + k + 1);
    end
  endtask

  // One clock: sample at the falling edge, push predicted results, record observations.
  task automatic tick();
    int p;
    int k;
    p = -1;
    @(negedge clk);
    smp_cyc = cyc;
    if (model_run) begin
      for (int i = 0; i < NREQ; i++) begin
        k = (ptr_m + i) % NREQ;
        if (p < 0 && req_valid_i[k]) p = k;
      end
    end
    if (p >= 0) begin
      exp_q.push_back('{p, fp_mac(req_a_i[p*XLEN +: XLEN], req_b_i[p*XLEN +: XLEN], req_c_i[p*XLEN +: XLEN]), cyc});
      ptr_m = (p + 1) % NREQ;
    end
    for (int i = 0; i < NREQ; i++)
      if (req_valid_i[i] && req_ready_o[i]) begin gnt_q.push_back(i); acc_cyc_q.push_back(cyc); end
    if (mac_valid_o) mv_cyc_q.push_back(cyc);
    if (res_valid_o) got_q.push_back('{int'(res_id_o), res_data_o, cyc});
    last_rdy  = req_ready_o;
    last_fd   = flush_done_o;
    last_busy = busy_o;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 40 && got_q.size() < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid_i = '0; flush_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; ptr_m = 0; model_run = 1'b1;
    clear_q();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; req_valid_i = '1;
    req_a_i = '1; req_b_i = '1; req_c_i = '1;
    #12;
    n_tests++; if (req_ready_o !== '0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", req_ready_o); end
    n_tests++; if (mac_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_mac_valid got %b exp 0", mac_valid_o); end
    n_tests++; if (mac_a_o !== '0) begin n_fail++; $display("FAIL reset_mac_a got %h exp 0", mac_a_o); end
    n_tests++; if (res_valid_o !== 1'b0 || res_data_o !== '0 || res_id_o !== '0) begin
      n_fail++; $display("FAIL reset_res got v=%b id=%0d d=%h exp all 0", res_valid_o, res_id_o, res_data_o); end
    n_tests++; if (flush_done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_status got done=%b busy=%b exp 0 0", flush_done_o, busy_o); end
`ifdef MAC32_SCHED_STATS_EN
    n_tests++; if (grant_cnt_o !== '0 || stall_cnt_o !== '0) begin
      n_fail++; $display("FAIL reset_stats got g=%h s=%0d exp 0", grant_cnt_o, stall_cnt_o); end
`endif
    do_reset();
  endtask

  task automatic test_single_op();
    do_reset();
    drive(2'b01);
    req_a_i[31:0] = 32'h3FC00000; req_b_i[31:0] = 32'h40000000; req_c_i[31:0] = 32'h40400000;
    tick();
    drive(2'b00);
    wait_results(1);
    n_tests++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL single_count got %0d exp 1", got_q.size()); end
    if (got_q.size() == 1 && acc_cyc_q.size() == 1 && mv_cyc_q.size() == 1) begin
      n_tests++; if (got_q[0].id !== 0) begin n_fail++; $display("FAIL single_id got %0d exp 0", got_q[0].id); end
      n_tests++; if (got_q[0].data !== 32'h40F00000) begin n_fail++; $display("FAIL single_data got %h exp 40f00000", got_q[0].data); end
      n_tests++; if (mv_cyc_q[0] - acc_cyc_q[0] !== 1) begin n_fail++; $display("FAIL single_issue_lat got %0d exp 1", mv_cyc_q[0] - acc_cyc_q[0]); end
      n_tests++; if (got_q[0].c - acc_cyc_q[0] !== LAT + 2) begin n_fail++; $display("FAIL single_res_lat got %0d exp %0d", got_q[0].c - acc_cyc_q[0], LAT + 2); end
    end
    n_tests++; if (mac_valid_o !== 1'b0 || mac_a_o !== 32'h3FC00000 || mac_c_o !== 32'h40400000) begin
      n_fail++; $display("FAIL single_mac_hold got v=%b a=%h c=%h exp 0 3fc00000 40400000", mac_valid_o, mac_a_o, mac_c_o); end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 6; i++) begin drive(2'b11); tick(); end
    drive(2'b00);
    wait_results(6);
    n_tests++; if (gnt_q.size() !== 6 || got_q.size() !== 6) begin
      n_fail++; $display("FAIL cont_count got g=%0d r=%0d exp 6 6", gnt_q.size(), got_q.size()); end
    for (int i = 0; i < 6 && i < gnt_q.size() && i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (gnt_q[i] !== i % 2) begin n_fail++; $display("FAIL cont_grant[%0d] got %0d exp %0d", i, gnt_q[i], i % 2); end
      n_tests++; if (got_q[i].id !== i % 2 || got_q[i].data !== exp_q[i].data) begin
        n_fail++; $display("FAIL cont_res[%0d] got id=%0d d=%h exp id=%0d d=%h", i, got_q[i].id, got_q[i].data, i % 2, exp_q[i].data); end
      n_tests++; if (got_q[i].c !== exp_q[0].c + LAT + 2 + i) begin
        n_fail++; $display("FAIL cont_cycle[%0d] got %0d exp %0d", i, got_q[i].c, exp_q[0].c + LAT + 2 + i); end
    end
  endtask

  task automatic test_fairness();
    clear_q();
    drive(2'b10); tick();
    drive(2'b11); tick();
    drive(2'b00);
    wait_results(2);
    n_tests++; if (gnt_q.size() !== 2) begin n_fail++; $display("FAIL fair_count got %0d exp 2", gnt_q.size()); end
    if (gnt_q.size() == 2) begin
      n_tests++; if (gnt_q[0] !== 1 || gnt_q[1] !== 0) begin n_fail++; $display("FAIL fair_grants got %0d,%0d exp 1,0", gnt_q[0], gnt_q[1]); end
    end
    n_tests++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL fair_results got %0d exp 2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (got_q[i].id !== exp_q[i].id || got_q[i].data !== exp_q[i].data) begin
        n_fail++; $display("FAIL fair_res[%0d] got id=%0d d=%h exp id=%0d d=%h", i, got_q[i].id, got_q[i].data, exp_q[i].id, exp_q[i].data); end
    end
  endtask

  task automatic test_flush();
    int rdy_bad;
    int fd_cyc;
    rdy_bad = 0; fd_cyc = -1;
    clear_q();
    drive(2'b11); tick();
    drive(2'b11); tick();
    flush_i = 1'b1; drive(2'b11); tick();
    model_run = 1'b0;
    for (int i = 0; i < 20 && fd_cyc < 0; i++) begin
      drive(2'b11); tick();
      if (last_rdy !== '0) rdy_bad++;
      if (last_fd === 1'b1) fd_cyc = smp_cyc;
    end
    n_tests++; if (rdy_bad !== 0) begin n_fail++; $display("FAIL flush_no_grant got %0d granting cycles exp 0", rdy_bad); end
    n_tests++; if (acc_cyc_q.size() !== 3 || got_q.size() !== 3) begin
      n_fail++; $display("FAIL flush_drained got acc=%0d res=%0d exp 3 3", acc_cyc_q.size(), got_q.size()); end
    if (acc_cyc_q.size() == 3) begin
      n_tests++; if (fd_cyc !== acc_cyc_q[2] + LAT + 3) begin n_fail++; $display("FAIL flush_done_cycle got %0d exp %0d", fd_cyc, acc_cyc_q[2] + LAT + 3); end
    end
    n_tests++; if (last_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_in_done got %b exp 0", last_busy); end
    flush_i = 1'b0; drive(2'b11); tick();
    n_tests++; if (last_rdy !== '0 || last_fd !== 1'b1) begin
      n_fail++; $display("FAIL flush_release_cycle got rdy=%b done=%b exp 0 1", last_rdy, last_fd); end
    model_run = 1'b1;
    drive(2'b11); tick();
    n_tests++; if (last_rdy === '0 || gnt_q.size() !== 4) begin
      n_fail++; $display("FAIL flush_resume got rdy=%b grants=%0d exp nonzero 4", last_rdy, gnt_q.size()); end
    drive(2'b00);
    wait_results(4);
    n_tests++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL flush_total got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (got_q[i].id !== exp_q[i].id || got_q[i].data !== exp_q[i].data) begin
        n_fail++; $display("FAIL flush_res[%0d] got id=%0d d=%h exp id=%0d d=%h", i, got_q[i].id, got_q[i].data, exp_q[i].id, exp_q[i].data); end
    end
  endtask

  task automatic test_reset_midflight();
    clear_q();
    drive(2'b11); tick();
    drive(2'b11); tick();
    drive(2'b00);
    #3;
    n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b exp 1", busy_o); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (mac_valid_o !== 1'b0 || busy_o !== 1'b0 || res_valid_o !== 1'b0 || mac_a_o !== '0) begin
      n_fail++; $display("FAIL midrst_outputs got mv=%b busy=%b rv=%b a=%h exp 0", mac_valid_o, busy_o, res_valid_o, mac_a_o); end
    @(posedge clk); #1;
    rst_n = 1'b1; ptr_m = 0; model_run = 1'b1;
    clear_q();
    for (int i = 0; i < 10; i++) tick();
    n_tests++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL midrst_no_result got %0d results exp 0", got_q.size()); end
  endtask

`ifdef MAC32_SCHED_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 2; i++) begin drive(2'b01); tick(); end
    for (int i = 0; i < 4; i++) begin drive(2'b11); tick(); end
    drive(2'b00);
    wait_results(6);
    tick(); tick();
    flush_i = 1'b1; tick();
    model_run = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(2'b01); tick(); end
    drive(2'b00); tick();
    flush_i = 1'b0; tick(); tick();
    model_run = 1'b1;
    n_tests++; if (grant_cnt_o[15:0] !== 16'd4 || grant_cnt_o[31:16] !== 16'd2) begin
      n_fail++; $display("FAIL stats_grants got %0d,%0d exp 4,2", grant_cnt_o[15:0], grant_cnt_o[31:16]); end
    n_tests++; if (stall_cnt_o !== 16'd3) begin n_fail++; $display("FAIL stats_stall got %0d exp 3", stall_cnt_o); end
    n_tests++; if (gnt_q.size() !== 6) begin n_fail++; $display("FAIL stats_grant_events got %0d exp 6", gnt_q.size()); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid_i = '0; flush_i = 1'b0; rst_n = 1'b0;
    req_a_i = '0; req_b_i = '0; req_c_i = '0;
    test_reset();
    test_single_op();
    test_contention();
    test_fairness();
    test_flush();
    test_reset_midflight();
`ifdef MAC32_SCHED_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
